// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out word serializer with valid/ready load and shift-enable stall.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

`ifdef PISO_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(NBITS);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_bit;
    logic               accept;
    logic               data_bit;
`ifdef PISO_PARITY_EN
    logic               par_q, par_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs are decoded from state so an async reset clears them in the same cycle.
    always_comb begin
        last_bit   = (state_q == SHIFT) && (cnt_q == CNT_W'(NBITS - 1));
        word_done  = last_bit && shift_en;
        load_ready = (state_q == IDLE) || word_done;
        accept     = load_valid && load_ready;
        ser_valid  = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        data_bit   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
`ifdef PISO_PARITY_EN
        ser_out    = (state_q == SHIFT) && ((cnt_q == CNT_W'(WIDTH)) ? par_q : data_bit);
`else
        ser_out    = (state_q == SHIFT) && data_bit;
`endif
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // Covers both IDLE loads and back-to-back reload on the final bit.
            state_d = SHIFT;
            sreg_d  = load_data;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            par_d   = ^load_data;
`endif
        end else if ((state_q == SHIFT) && shift_en) begin
            if (last_bit) begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (MSB_FIRST) begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: MSB-first and LSB-first instances side by side.
// Parity-trailer expectations follow PISO_PARITY_EN when it is defined.
module tb_piso_bit_serializer;

`ifdef PISO_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    typedef struct {
        int unsigned inst;
        logic [7:0]  word;
        logic [7:0]  seq;
        logic        par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ld;
    logic       se;
    logic [1:0] lv, lr, so, sv, bz, wd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load_data(ld), .load_valid(lv[0]), .load_ready(lr[0]),
        .shift_en(se), .ser_out(so[0]), .ser_valid(sv[0]), .busy(bz[0]), .word_done(wd[0])
    );

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load_data(ld), .load_valid(lv[1]), .load_ready(lr[1]),
        .shift_en(se), .ser_out(so[1]), .ser_valid(sv[1]), .busy(bz[1]), .word_done(wd[1])
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send_word(input int unsigned i, input vec_t v, input int idx);
        logic eb;
        @(posedge clk); #1;
        ld    = v.word;
        lv[i] = 1'b1;
        se    = 1'b1;
        #1;
        chk($sformatf("v%0d_ready_idle", idx), lr[i], 1'b1);
        @(posedge clk); #1;
        lv[i] = 1'b0;
        #1;
        for (int k = 0; k < NB; k++) begin
            eb = (k < 8) ? v.seq[7-k] : v.par;
            chk($sformatf("v%0d_valid_b%0d", idx, k), sv[i], 1'b1);
            chk($sformatf("v%0d_out_b%0d", idx, k), so[i], eb);
            chk($sformatf("v%0d_busy_b%0d", idx, k), bz[i], 1'b1);
            chk($sformatf("v%0d_done_b%0d", idx, k), wd[i], k == NB - 1);
            chk($sformatf("v%0d_ready_b%0d", idx, k), lr[i], k == NB - 1);
            @(posedge clk); #2;
        end
        chk($sformatf("v%0d_valid_after", idx), sv[i], 1'b0);
        chk($sformatf("v%0d_out_after", idx), so[i], 1'b0);
        chk($sformatf("v%0d_busy_after", idx), bz[i], 1'b0);
        chk($sformatf("v%0d_ready_after", idx), lr[i], 1'b1);
    endtask

    function automatic logic msb_bit(input logic [7:0] w, input int k);
        return (k < 8) ? w[7-k] : ^w;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [3:0] hist;
        int         dets;
        int         vcnt;
        logic [7:0] w;

        tbl[0] = '{0, 8'hA5, 8'hA5, 1'b0};
        tbl[1] = '{0, 8'h07, 8'h07, 1'b1};
        tbl[2] = '{0, 8'h81, 8'h81, 1'b0};
        tbl[3] = '{1, 8'h01, 8'h80, 1'b1};
        tbl[4] = '{1, 8'h0B, 8'hD0, 1'b1};
        tbl[5] = '{1, 8'hC8, 8'h13, 1'b1};

        reset = 1'b0;
        lv    = 2'b00;
        se    = 1'b0;
        ld    = 8'h00;
        #12;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_out%0d", i), so[i], 1'b0);
            chk($sformatf("rst_valid%0d", i), sv[i], 1'b0);
            chk($sformatf("rst_busy%0d", i), bz[i], 1'b0);
            chk($sformatf("rst_done%0d", i), wd[i], 1'b0);
        end
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rst_ready0", lr[0], 1'b1);
        chk("rst_ready1", lr[1], 1'b1);

        for (int n = 0; n < 6; n++) begin
            send_word(tbl[n].inst, tbl[n], n);
        end

        // Async reset in the middle of a word.
        @(posedge clk); #1;
        ld = 8'hFF; lv[0] = 1'b1; se = 1'b1;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("mid_busy_pre", bz[0], 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_out", so[0], 1'b0);
        chk("mid_rst_valid", sv[0], 1'b0);
        chk("mid_rst_busy", bz[0], 1'b0);
        chk("mid_rst_done", wd[0], 1'b0);
        #1;
        reset = 1'b1;
        @(posedge clk); #2;
        chk("mid_rst_ready", lr[0], 1'b1);
        chk("mid_rst_dropped", sv[0], 1'b0);

        // Back-to-back words feeding a 1010 detector model.
        @(posedge clk); #1;
        ld = 8'hA0; lv[0] = 1'b1; se = 1'b1;
        @(posedge clk); #1;
        ld = 8'h0A;
        #1;
        hist = 4'b0000;
        dets = 0;
        for (int k = 0; k < 2 * NB; k++) begin
            w = (k < NB) ? 8'hA0 : 8'h0A;
            chk($sformatf("b2b_valid_b%0d", k), sv[0], 1'b1);
            chk($sformatf("b2b_out_b%0d", k), so[0], msb_bit(w, k % NB));
            if (k == NB - 1) chk("b2b_ready_last", lr[0], 1'b1);
            hist = {hist[2:0], so[0]};
            if (hist == 4'b1010) dets++;
            @(posedge clk); #1;
            if (k == NB - 1) lv[0] = 1'b0;
            #1;
        end
        chk("b2b_valid_end", sv[0], 1'b0);
        chk_int("b2b_detections", dets, 2);

        // Stall for three cycles on bit 2, with an ignored load offered meanwhile.
        @(posedge clk); #1;
        ld = 8'hF0; lv[0] = 1'b1; se = 1'b1;
        @(posedge clk); #1;
        lv[0] = 1'b0;
        #1;
        vcnt = 0;
        for (int k = 0; k < NB; k++) begin
            if (k == 2) begin
                for (int s = 0; s < 3; s++) begin
                    se = 1'b0; lv[0] = 1'b1; ld = 8'h55;
                    #1;
                    chk($sformatf("stall_out_s%0d", s), so[0], 1'b1);
                    chk($sformatf("stall_valid_s%0d", s), sv[0], 1'b1);
                    chk($sformatf("stall_ready_s%0d", s), lr[0], 1'b0);
                    chk($sformatf("stall_done_s%0d", s), wd[0], 1'b0);
                    vcnt++;
                    @(posedge clk); #2;
                end
                se = 1'b1; lv[0] = 1'b0;
                #1;
            end
            chk($sformatf("stall_bit%0d", k), so[0], msb_bit(8'hF0, k));
            chk($sformatf("stall_vld%0d", k), sv[0], 1'b1);
            vcnt++;
            @(posedge clk); #2;
        end
        chk("stall_end_valid", sv[0], 1'b0);
        chk("stall_end_busy", bz[0], 1'b0);
        chk_int("stall_cycles", vcnt, NB + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
